// File: rtl/ifetch_unit.sv
// Instruction fetch: pc register, combinational ROM lookup, 2-entry {pc, word} buffer,
// redirect handling and a RUN/HALT/ERR control FSM.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted,
    output logic        misalign_err
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HALT = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_ent_t;

    logic [31:0] pc;
    logic [1:0]  count;
    logic [1:0]  state;
    fetch_ent_t  head, tail, new_ent;
    logic        redirect, pop, fetch, is_halt;

    assign imem_addr   = pc;
    assign instr_valid = (count != 2'd0) && (state != ERR);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign halted      = (state == HALT) && (count == 2'd0);

    // A redirect wins over both fetch and pop in the same cycle.
    assign redirect = (state == RUN) && branch_valid;
    assign pop      = instr_valid && instr_ready && !redirect;
    assign fetch    = (state == RUN) && !branch_valid && ((count != 2'd2) || pop);
    assign is_halt  = (imem_data[31:26] == HALT_OPCODE);
    assign new_ent  = '{pc: pc, word: imem_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            count        <= 2'd0;
            state        <= RUN;
            misalign_err <= 1'b0;
            head         <= '0;
            tail         <= '0;
        end else if (redirect) begin
            count <= 2'd0;
            if (branch_target[1:0] == 2'b00) begin
                pc <= branch_target;
            end else begin
                state        <= ERR;
                misalign_err <= 1'b1;
            end
        end else begin
            // head is always the oldest entry; tail is only meaningful when count==2
            case ({fetch, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= new_ent;
                    end else begin
                        head <= new_ent;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) head <= new_ent;
                    else               tail <= new_ent;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
            if (fetch) begin
                if (is_halt) state <= HALT;
                else         pc    <= pc + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized + directed bench for ifetch_unit: a queue-based reference model predicts
// delivered instructions into a scoreboard that a negedge monitor drains and checks.
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;
    typedef enum int {M_RUN, M_HALT, M_ERR} mode_e;

    logic        clk = 1'b0;
    logic        reset, branch_valid, instr_ready;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_data, instr, instr_pc;
    logic        instr_valid, halted, misalign_err;

    logic [31:0] rom [256];
    ent_t        mq[$];
    ent_t        exp_q[$];
    logic [31:0] m_pc;
    mode_e       m_mode;
    bit          chk_en = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    ifetch_unit #(.RESET_PC(RESET_PC), .HALT_OPCODE(6'd63)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // ROM: table in the low 1 KiB, address-derived non-halt words elsewhere
    assign imem_data = (imem_addr[31:10] == 22'd0) ? rom[imem_addr[9:2]] : {6'd1, imem_addr[27:2]};

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        if (a[31:10] == 22'd0) return rom[a[9:2]];
        return {6'd1, a[27:2]};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0]  op;
        logic [25:0] lo;
        op = 6'($urandom_range(0, 62));
        lo = 26'($urandom);
        return {op, lo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances at the same edge as the DUT.
    task automatic step(input logic rst, input logic bv, input logic [31:0] bt, input logic rdy);
        logic [31:0] w;
        bit          pop;
        int          sz;
        reset = rst; branch_valid = bv; branch_target = bt; instr_ready = rdy;
        w   = rom_read(m_pc);
        sz  = mq.size();
        pop = (m_mode != M_ERR) && (sz > 0) && rdy;
        if (!rst && !(m_mode == M_RUN && bv) && pop) exp_q.push_back(mq[0]);
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_pc = RESET_PC; m_mode = M_RUN;
        end else if (m_mode == M_RUN && bv) begin
            mq.delete();
            if (bt[1:0] == 2'b00) m_pc = bt;
            else                  m_mode = M_ERR;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_mode == M_RUN && (sz < 2 || pop)) begin
                mq.push_back('{pc: m_pc, word: w});
                if (w[31:26] == 6'd63) m_mode = M_HALT;
                else                   m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    // Monitor: control outputs against the model, transfers against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(m_mode != M_ERR && mq.size() != 0));
            chk("halted", 32'(halted), 32'(m_mode == M_HALT && mq.size() == 0));
            chk("misalign_err", 32'(misalign_err), 32'(m_mode == M_ERR));
            if (!reset && instr_valid && instr_ready && !(branch_valid && m_mode == M_RUN)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_xfer", 32'(instr_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_pc", instr_pc, e.pc);
                    chk("xfer_word", instr, e.word);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = rand_word();
        m_pc = RESET_PC; m_mode = M_RUN;
        @(posedge clk); #1;
        chk_en = 1;
        step(1, 0, 0, 0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);

        // streaming at one per cycle
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // backpressure fills the buffer, then drains back-to-back
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_pc_head", instr_pc, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // redirect with a full buffer
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h40, 0);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        step(0, 0, 0, 0);
        chk("redir_pc", instr_pc, 32'h40);
        chk("redir_word", instr, rom[16]);

        // pc wrap
        step(0, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_post", imem_addr, 32'h0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);

        // halt opcode at address 8
        rom[2] = {6'd63, 26'd0};
        step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_addr", imem_addr, 32'h8);
        step(0, 1, 32'h40, 1);
        chk("halt_ign_br", imem_addr, 32'h8);
        chk("halt_still", 32'(halted), 32'd1);
        rom[2] = rand_word();

        // misaligned redirect is sticky until reset
        step(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
        step(0, 1, 32'h42, 1);
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        step(0, 1, 32'h80, 1);
        step(0, 0, 0, 1);
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        step(1, 0, 0, 1);
        chk("mis_clr", 32'(misalign_err), 32'd0);
        chk("mis_rst_addr", imem_addr, RESET_PC);
        chk("mis_rst_instr", instr, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // random traffic with sparse halts, redirects and resets
        reset = 1'b1;
        for (int i = 0; i < 256; i++)
            if ($urandom_range(0, 49) == 0) rom[i] = {6'd63, 26'($urandom)};
        step(1, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            logic        r, b, rd;
            logic [31:0] t;
            rd = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 19) == 0);
            t  = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
            r  = ($urandom_range(0, 149) == 0) || (m_mode != M_RUN && $urandom_range(0, 14) == 0);
            step(r, b, t, rd);
        end

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 6'd63, the opcode (bits 31:26) that halts fetch.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to the instruction ROM; ROM returns the word combinationally in the same cycle.
REQ-006 SHALL have port imem_data  input  32  instruction word from the ROM for imem_addr.
REQ-007 SHALL have port branch_valid  input  1  one-cycle redirect request from the decode/execute stage.
REQ-008 SHALL have port branch_target  input  32  redirect byte address, sampled when branch_valid=1.
REQ-009 SHALL have port instr_valid  output  1  head of the instruction buffer is valid.
REQ-010 SHALL have port instr  output  32  instruction word at the buffer head.
REQ-011 SHALL have port instr_pc  output  32  byte address of instr.
REQ-012 SHALL have port instr_ready  input  1  consumer accepts head; transfer when instr_valid && instr_ready.
REQ-013 SHALL have port halted  output  1  fetch stopped on HALT_OPCODE and buffer drained.
REQ-014 SHALL have port misalign_err  output  1  sticky error, redirect target not word aligned.

Function
REQ-015 SHALL hold a 32-bit pc register and drive imem_addr = pc at all times.
REQ-016 SHALL contain a 2-entry FIFO of {pc, word} pairs with a 2-bit count (0..2); head drives instr/instr_pc; instr_valid = (count != 0).
REQ-017 SHALL implement FSM states RUN, HALT, ERR.
REQ-018 In RUN, a fetch SHALL occur when no redirect is present and (count < 2 or a pop occurs that cycle): push {pc, imem_data}, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-019 Simultaneous push and pop with count=2 SHALL leave count=2 with the next entry at head; with count=1, count stays 1 and the new entry becomes head.
REQ-020 When a fetched word has bits 31:26 == HALT_OPCODE, the word SHALL still be pushed, pc SHALL NOT advance, and FSM SHALL go RUN -> HALT.
REQ-021 In HALT no fetch SHALL occur; the buffer SHALL continue to drain via pops; halted = (state==HALT && count==0).
REQ-022 In RUN, branch_valid=1 with branch_target[1:0]==0 SHALL flush the FIFO (count <= 0), set pc <= branch_target, and suppress both fetch and pop that cycle; redirect has priority over fetch and pop.
REQ-023 In RUN, branch_valid=1 with branch_target[1:0]!=0 SHALL flush the FIFO, leave pc unchanged, and go RUN -> ERR.
REQ-024 In ERR, misalign_err=1, instr_valid=0, no fetch; only reset exits ERR.
REQ-025 branch_valid in HALT or ERR SHALL be ignored.
REQ-026 A fetch whose imem_data contains any X/Z bit SHALL still be pushed unchanged (no X filtering); bench flags it.
REQ-027 Latency: an instruction at pc SHALL appear at instr one cycle after the fetch cycle when the FIFO was empty.
REQ-028 Sustained throughput with instr_ready=1 SHALL be one instruction per cycle.

Reset
REQ-029 With reset=1 at a rising edge: pc <= RESET_PC, count <= 0, state <= RUN, misalign_err <= 0; thus instr_valid=0, halted=0 next cycle.
REQ-030 Reset SHALL override all inputs, including branch_valid in the same cycle, and abort HALT/ERR or a partially drained FIFO.
REQ-031 Outputs instr/instr_pc SHALL read as 0 when count==0 after reset (storage cleared by reset).

Verification
REQ-032 Reset, instr_ready=1, ROM words W0..W3 at 0,4,8,12 -> instr_pc 0,4,8,12 on consecutive cycles starting cycle 1 after reset release.
REQ-033 instr_ready=0 for 5 cycles from reset -> count saturates at 2 (entries pc 0,4), imem_addr holds 8; raising instr_ready delivers 0,4,8 back-to-back.
REQ-034 branch_valid=1, branch_target=32'h40 while count=2 -> next cycle instr_valid=0, imem_addr=32'h40; following cycle instr_pc=32'h40.
REQ-035 Word at address 8 = {6'd63, 26'd0}, instr_ready=1 -> entries 0,4,8 delivered, imem_addr stays 8, halted=1 the cycle after pc 8 pops; branch_valid then ignored.
REQ-036 branch_valid=1, branch_target=32'h42 -> misalign_err=1 next cycle, instr_valid=0, stays until reset; reset pulse -> misalign_err=0, fetch resumes at RESET_PC.
REQ-037 pc forced to 32'hFFFF_FFFC by redirect -> next fetch address 32'h0000_0000.
